arp_rx_parser: RTL and testbench
================================

Name: arp_rx_parser

Overview:
- Successor ARP receive parser. Consumes the byte stream of the ARP payload that follows the Ethernet header, once the EtherType stage has flagged ARP.
- Validates every header field and matches the target IP against up to NUM_IP local addresses.
- Hands the decoded request or reply downstream through a valid/ready slot with one-entry buffering.
- Reports every dropped packet with a reason code and keeps saturating statistics counters.

Parameters:
NUM_IP, 2, number of local IPv4 addresses matched (1..8)
CNT_W, 16, width of each statistics counter
ACCEPT_GRAT, 1, 1 = accept gratuitous ARP (SPA==TPA) even with no local IP match

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
data_in  in  8  ARP payload byte
data_valid  in  1  data_in valid; high continuously for the whole frame
eth_type_arp_valid  in  1  start pulse; coincides with byte 0 (HTYPE MSB) and data_valid
local_mac  in  48  own MAC address
local_ip  in  32*NUM_IP  own IPs; entry i at bits [32*i+31:32*i]
ip_en  in  NUM_IP  per-entry enable
m_valid  out  1  decoded packet available
m_ready  in  1  downstream accepts
m_oper  out  1  0 = request, 1 = reply
m_sha  out  48  sender MAC
m_spa  out  32  sender IP
m_tha  out  48  target MAC
m_ip_idx  out  $clog2(NUM_IP) (min 1)  matched local IP index
m_grat  out  1  gratuitous ARP
drop_pulse  out  1  one-cycle pulse per dropped packet
drop_reason  out  3  reason code, valid with drop_pulse
cnt_ok  out  CNT_W  packets accepted into the slot
cnt_drop  out  CNT_W  packets dropped

Behaviour:
- Reset: all outputs 0, FSM in IDLE, byte counter 0. Reset is asynchronous and mid-packet reset abandons the packet with no drop report.
- FSM states: IDLE, PARSE, DISCARD.
- IDLE to PARSE: on eth_type_arp_valid & data_valid. That byte is counted as index 0.
- PARSE: a 5-bit counter advances one per byte, indices 0..27. Fields are checked as they arrive:
  - HTYPE = 0x0001, PTYPE = 0x0800, HLEN = 6, PLEN = 4, OPER in {1, 2}.
  - SHA (8..13), SPA (14..17), THA (18..23) and TPA (24..27) are captured into shadow registers.
- Header or OPER mismatch: go to DISCARD. Drop is reported after byte 27 or on truncation, whichever comes first, with the first failing reason only.
- Decision on the edge sampling byte 27, using TPA assembled with data_in:
  - ip_match: lowest i with ip_en[i] & (TPA == local_ip[i]).
  - grat: SPA == TPA.
  - Accept if (ip_match | (ACCEPT_GRAT & grat)) & (OPER == 1 | THA == local_mac | grat).
  - When accepted via grat alone, m_ip_idx = 0.
- Accept when the slot is free (!m_valid, or m_valid & m_ready on the same edge): load the m_* registers, set m_valid, increment cnt_ok. m_valid rises in the cycle after byte 27 (latency 1).
- Accept when the slot is occupied and not being released: reason OVERFLOW. The held packet is unchanged.
- m_* outputs are stable while m_valid & !m_ready. m_valid clears on m_valid & m_ready unless a new load happens on that same edge.
- After byte 27 go to DISCARD. Trailing padding and FCS bytes are ignored.
- DISCARD: return to IDLE when data_valid is low.
- Truncation: data_valid low in PARSE before byte 27 gives reason TRUNC and a move to IDLE.
- eth_type_arp_valid while in PARSE or DISCARD:
  - An unfinished packet in PARSE is dropped with TRUNC.
  - The new packet restarts at index 0 on that same byte.
- Reason codes: 1 HDR, 2 OPER, 3 NO_IP, 4 THA, 5 TRUNC, 6 OVERFLOW.
- drop_pulse is high for exactly one cycle per dropped packet and increments cnt_drop.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Request 0x0001/0x0800/6/4/oper 1, TPA = local_ip[1] = 192.168.0.10 with ip_en = 2'b11, m_ready held high -> m_valid for 1 cycle, 1 cycle after byte 27; m_oper = 0, m_ip_idx = 1, m_sha and m_spa match the stream, cnt_ok = 1.
- Reply, oper 2, with THA = 0x02_00_00_00_00_01 != local_mac -> drop_pulse, drop_reason = 4, m_valid stays 0, cnt_drop = 1.
- PTYPE = 0x86DD -> drop_reason = 1 after byte 27. Then data_valid drops at byte 12 of the next packet -> drop_reason = 5.
- m_ready = 0, two valid requests back-to-back -> first is held unchanged, second gives drop_reason = 6. Then m_ready = 1 on the edge of a third byte 27 -> the third loads with no overflow.
- Gratuitous, SPA = TPA = 10.0.0.5 with no local match, ACCEPT_GRAT = 1 -> m_grat = 1, m_ip_idx = 0. Repeat with ip_en = 0 and a non-grat request -> drop_reason = 3.
- Assert areset at byte 15 -> all outputs 0 immediately. A fresh packet after release parses normally.

Source files
------------

// File: rtl/arp_rx_parser.sv
// ARP payload parser: field validation, local IP match, one-entry output slot,
// drop reporting with reason codes and saturating statistics.
module arp_rx_parser #(
  parameter int NUM_IP      = 2,
  parameter int CNT_W       = 16,
  parameter int ACCEPT_GRAT = 1,
  localparam int IDX_W      = (NUM_IP > 1) ? $clog2(NUM_IP) : 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [7:0]           data_in,
  input  logic                 data_valid,
  input  logic                 eth_type_arp_valid,
  input  logic [47:0]          local_mac,
  input  logic [32*NUM_IP-1:0] local_ip,
  input  logic [NUM_IP-1:0]    ip_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_oper,
  output logic [47:0]          m_sha,
  output logic [31:0]          m_spa,
  output logic [47:0]          m_tha,
  output logic [IDX_W-1:0]     m_ip_idx,
  output logic                 m_grat,
  output logic                 drop_pulse,
  output logic [2:0]           drop_reason,
  output logic [CNT_W-1:0]     cnt_ok,
  output logic [CNT_W-1:0]     cnt_drop
);

  typedef enum logic [1:0] {IDLE, PARSE, DISCARD} state_t;

  localparam logic [2:0] R_HDR = 3'd1, R_OPER = 3'd2, R_NOIP = 3'd3,
                         R_THA = 3'd4, R_TRUNC = 3'd5, R_OVF = 3'd6;

  state_t state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [2:0] pend_q, pend_d;
  logic oper_q, oper_d;
  logic [47:0] sha_q, sha_d, tha_q, tha_d;
  logic [31:0] spa_q, spa_d;
  logic [23:0] tpa_q, tpa_d;

  logic m_valid_q, m_valid_d, m_oper_q, m_oper_d, m_grat_q, m_grat_d;
  logic [47:0] m_sha_q, m_sha_d, m_tha_q, m_tha_d;
  logic [31:0] m_spa_q, m_spa_d;
  logic [IDX_W-1:0] m_idx_q, m_idx_d;
  logic drop_q, drop_d;
  logic [2:0] reason_q, reason_d;
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d, cnt_drop_q, cnt_drop_d;

  logic start, hit, grat, dest_ok, tha_ok, slot_free, load;
  logic [4:0] cur_idx;
  logic [2:0] chk, drop_code;
  logic [31:0] tpa_full;
  logic [IDX_W-1:0] hit_idx;

  function automatic logic [2:0] byte_check(input logic [4:0] idx, input logic [7:0] d);
    logic [2:0] r;
    r = 3'd0;
    case (idx)
      5'd0: if (d != 8'h00) r = R_HDR;
      5'd1: if (d != 8'h01) r = R_HDR;
      5'd2: if (d != 8'h08) r = R_HDR;
      5'd3: if (d != 8'h00) r = R_HDR;
      5'd4: if (d != 8'h06) r = R_HDR;
      5'd5: if (d != 8'h04) r = R_HDR;
      5'd6: if (d != 8'h00) r = R_OPER;
      5'd7: if (d != 8'h01 && d != 8'h02) r = R_OPER;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    start     = eth_type_arp_valid & data_valid;
    cur_idx   = start ? 5'd0 : idx_q;
    chk       = byte_check(cur_idx, data_in);
    tpa_full  = {tpa_q, data_in};
    hit       = 1'b0;
    hit_idx   = '0;
    // Descending scan so the lowest matching entry wins.
    for (int i = NUM_IP - 1; i >= 0; i--) begin
      if (ip_en[i] && (tpa_full == local_ip[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    grat      = (spa_q == tpa_full);
    dest_ok   = hit | ((ACCEPT_GRAT != 0) & grat);
    tha_ok    = !oper_q | (tha_q == local_mac) | grat;
    slot_free = !m_valid_q | m_ready;

    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    oper_d    = oper_q;
    sha_d     = sha_q;
    spa_d     = spa_q;
    tha_d     = tha_q;
    tpa_d     = tpa_q;
    load      = 1'b0;
    drop_code = 3'd0;

    if (data_valid && (start || state_q == PARSE)) begin
      if (cur_idx == 5'd7) oper_d = data_in[1];
      if (cur_idx >= 5'd8  && cur_idx <= 5'd13) sha_d = {sha_q[39:0], data_in};
      if (cur_idx >= 5'd14 && cur_idx <= 5'd17) spa_d = {spa_q[23:0], data_in};
      if (cur_idx >= 5'd18 && cur_idx <= 5'd23) tha_d = {tha_q[39:0], data_in};
      if (cur_idx >= 5'd24 && cur_idx <= 5'd26) tpa_d = {tpa_q[15:0], data_in};
    end

    if (start) begin
      if (state_q == PARSE) drop_code = R_TRUNC;
      else if (state_q == DISCARD) drop_code = pend_q;
      idx_d   = 5'd1;
      pend_d  = chk;
      state_d = (chk != 3'd0) ? DISCARD : PARSE;
    end else begin
      case (state_q)
        PARSE: begin
          if (!data_valid) begin
            drop_code = R_TRUNC;
            state_d   = IDLE;
            idx_d     = 5'd0;
          end else if (chk != 3'd0) begin
            pend_d  = chk;
            state_d = DISCARD;
            idx_d   = idx_q + 5'd1;
          end else if (idx_q == 5'd27) begin
            state_d = DISCARD;
            pend_d  = 3'd0;
            if (!dest_ok)        drop_code = R_NOIP;
            else if (!tha_ok)    drop_code = R_THA;
            else if (!slot_free) drop_code = R_OVF;
            else                 load      = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        DISCARD: begin
          // A header error is held here until byte 27 or truncation.
          if (!data_valid) begin
            drop_code = pend_q;
            pend_d    = 3'd0;
            state_d   = IDLE;
            idx_d     = 5'd0;
          end else if (pend_q != 3'd0) begin
            if (idx_q == 5'd27) begin
              drop_code = pend_q;
              pend_d    = 3'd0;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end

    m_valid_d = load | (m_valid_q & !m_ready);
    m_oper_d  = m_oper_q;
    m_sha_d   = m_sha_q;
    m_spa_d   = m_spa_q;
    m_tha_d   = m_tha_q;
    m_idx_d   = m_idx_q;
    m_grat_d  = m_grat_q;
    if (load) begin
      m_oper_d = oper_q;
      m_sha_d  = sha_q;
      m_spa_d  = spa_q;
      m_tha_d  = tha_q;
      m_idx_d  = hit ? hit_idx : '0;
      m_grat_d = grat;
    end

    drop_d     = (drop_code != 3'd0);
    reason_d   = drop_code;
    cnt_ok_d   = cnt_ok_q;
    cnt_drop_d = cnt_drop_q;
    if (load && cnt_ok_q != '1)     cnt_ok_d   = cnt_ok_q + CNT_W'(1);
    if (drop_d && cnt_drop_q != '1) cnt_drop_d = cnt_drop_q + CNT_W'(1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pend_q     <= '0;
      oper_q     <= 1'b0;
      sha_q      <= '0;
      spa_q      <= '0;
      tha_q      <= '0;
      tpa_q      <= '0;
      m_valid_q  <= 1'b0;
      m_oper_q   <= 1'b0;
      m_sha_q    <= '0;
      m_spa_q    <= '0;
      m_tha_q    <= '0;
      m_idx_q    <= '0;
      m_grat_q   <= 1'b0;
      drop_q     <= 1'b0;
      reason_q   <= '0;
      cnt_ok_q   <= '0;
      cnt_drop_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      oper_q     <= oper_d;
      sha_q      <= sha_d;
      spa_q      <= spa_d;
      tha_q      <= tha_d;
      tpa_q      <= tpa_d;
      m_valid_q  <= m_valid_d;
      m_oper_q   <= m_oper_d;
      m_sha_q    <= m_sha_d;
      m_spa_q    <= m_spa_d;
      m_tha_q    <= m_tha_d;
      m_idx_q    <= m_idx_d;
      m_grat_q   <= m_grat_d;
      drop_q     <= drop_d;
      reason_q   <= reason_d;
      cnt_ok_q   <= cnt_ok_d;
      cnt_drop_q <= cnt_drop_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_oper      = m_oper_q;
  assign m_sha       = m_sha_q;
  assign m_spa       = m_spa_q;
  assign m_tha       = m_tha_q;
  assign m_ip_idx    = m_idx_q;
  assign m_grat      = m_grat_q;
  assign drop_pulse  = drop_q;
  assign drop_reason = reason_q;
  assign cnt_ok      = cnt_ok_q;
  assign cnt_drop    = cnt_drop_q;

endmodule

// File: tb/tb_arp_rx_parser.sv
// Self-checking bench for arp_rx_parser: directed scenarios plus randomized
// packets checked against a field-level behavioural model.
module tb_arp_rx_parser;
  localparam int NUM_IP = 2;
  localparam int CNT_W  = 16;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic data_valid = 1'b0;
  logic eth = 1'b0;
  logic [47:0] local_mac;
  logic [63:0] local_ip;
  logic [1:0] ip_en;
  logic m_ready;
  logic m_valid, m_oper, m_grat, drop_pulse;
  logic [47:0] m_sha, m_tha;
  logic [31:0] m_spa;
  logic [0:0] m_ip_idx;
  logic [2:0] drop_reason;
  logic [CNT_W-1:0] cnt_ok, cnt_drop;

  arp_rx_parser #(.NUM_IP(NUM_IP), .CNT_W(CNT_W), .ACCEPT_GRAT(1)) dut (
    .aclk(aclk), .areset(areset), .data_in(data_in), .data_valid(data_valid),
    .eth_type_arp_valid(eth), .local_mac(local_mac), .local_ip(local_ip),
    .ip_en(ip_en), .m_valid(m_valid), .m_ready(m_ready), .m_oper(m_oper),
    .m_sha(m_sha), .m_spa(m_spa), .m_tha(m_tha), .m_ip_idx(m_ip_idx),
    .m_grat(m_grat), .drop_pulse(drop_pulse), .drop_reason(drop_reason),
    .cnt_ok(cnt_ok), .cnt_drop(cnt_drop)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int exp_ok = 0;
  int exp_drop = 0;
  logic [7:0] pkt [0:27];
  logic [2:0] drop_log [$];

  always @(negedge aclk) if (drop_pulse) drop_log.push_back(drop_reason);

  task automatic build(input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
                       input logic [47:0] tha, input logic [31:0] tpa);
    pkt[0] = 8'h00; pkt[1] = 8'h01; pkt[2] = 8'h08; pkt[3] = 8'h00;
    pkt[4] = 8'h06; pkt[5] = 8'h04; pkt[6] = op[15:8]; pkt[7] = op[7:0];
    for (int i = 0; i < 6; i++) pkt[8+i]  = sha[47-8*i -: 8];
    for (int i = 0; i < 4; i++) pkt[14+i] = spa[31-8*i -: 8];
    for (int i = 0; i < 6; i++) pkt[18+i] = tha[47-8*i -: 8];
    for (int i = 0; i < 4; i++) pkt[24+i] = tpa[31-8*i -: 8];
  endtask

  task automatic send_bytes(input int n, input bit ready_last);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      data_valid = 1'b1;
      eth = (i == 0);
      data_in = pkt[i];
      if (ready_last && i == 27) m_ready = 1'b1;
    end
  endtask

  task automatic finish_pkt(input int npad);
    for (int k = 0; k < npad; k++) begin
      data_valid = 1'b1; eth = 1'b0; data_in = 8'($urandom);
      @(negedge aclk);
    end
    data_valid = 1'b0; eth = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  // Expected outcome of the packet held in pkt when n bytes are delivered:
  // 0 = accepted (slot assumed free), otherwise the drop reason.
  function automatic logic [2:0] model(input int n, output logic [0:0] idx, output logic grat);
    logic [15:0] htype, ptype, op;
    logic [47:0] tha;
    logic [31:0] spa, tpa;
    bit hit;
    htype = {pkt[0], pkt[1]};
    ptype = {pkt[2], pkt[3]};
    op    = {pkt[6], pkt[7]};
    tha   = {pkt[18], pkt[19], pkt[20], pkt[21], pkt[22], pkt[23]};
    spa   = {pkt[14], pkt[15], pkt[16], pkt[17]};
    tpa   = {pkt[24], pkt[25], pkt[26], pkt[27]};
    idx = 1'b0; grat = 1'b0; hit = 1'b0;
    if (n >= 8) begin
      if (htype != 16'h0001 || ptype != 16'h0800 || pkt[4] != 8'd6 || pkt[5] != 8'd4) return 3'd1;
      if (op != 16'd1 && op != 16'd2) return 3'd2;
    end
    if (n < 28) return 3'd5;
    grat = (spa == tpa);
    for (int i = 0; i < NUM_IP; i++)
      if (!hit && ip_en[i] && local_ip[32*i +: 32] == tpa) begin hit = 1'b1; idx = 1'(i); end
    if (!(hit || grat)) return 3'd3;
    if (!(op == 16'd1 || tha == local_mac || grat)) return 3'd4;
    return 3'd0;
  endfunction

  task automatic test_reset();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop got %0b want 0", drop_pulse); end
    checks++; if (cnt_ok !== '0 || cnt_drop !== '0) begin errors++; $display("FAIL reset_cnt got ok=%0d drop=%0d want 0/0", cnt_ok, cnt_drop); end
    checks++; if ({m_sha, m_spa, m_tha, m_ip_idx, m_grat, m_oper, drop_reason} !== '0) begin errors++; $display("FAIL reset_fields got sha=%h spa=%h tha=%h want 0", m_sha, m_spa, m_tha); end
  endtask

  task automatic test_request();
    logic [47:0] sha;
    logic [31:0] spa;
    sha = {16'h0A0B, 32'($urandom)};
    spa = {16'h0A0A, 16'($urandom)};
    m_ready = 1'b1; ip_en = 2'b11;
    drop_log.delete();
    build(16'd1, sha, spa, 48'h0, 32'hC0A8000A);
    send_bytes(28, 1'b0);
    @(negedge aclk);
    exp_ok++;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL req_valid got %0b want 1", m_valid); end
    checks++; if (m_oper !== 1'b0 || m_ip_idx !== 1'b1) begin errors++; $display("FAIL req_oper_idx got %0b/%0d want 0/1", m_oper, m_ip_idx); end
    checks++; if (m_sha !== sha || m_spa !== spa) begin errors++; $display("FAIL req_sha_spa got %h/%h want %h/%h", m_sha, m_spa, sha, spa); end
    checks++; if (cnt_ok !== CNT_W'(exp_ok)) begin errors++; $display("FAIL req_cnt_ok got %0d want %0d", cnt_ok, exp_ok); end
    data_in = 8'($urandom); eth = 1'b0;
    @(negedge aclk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL req_valid_one_cycle got %0b want 0", m_valid); end
    finish_pkt(1);
    checks++; if (drop_log.size() != 0) begin errors++; $display("FAIL req_no_drop got %0d drops want 0", drop_log.size()); end
  endtask

  task automatic test_tha_miss();
    build(16'd2, 48'h001122334455, 32'h0A0A0101, 48'h020000000001, local_ip[31:0]);
    send_bytes(28, 1'b0);
    @(negedge aclk);
    exp_drop++;
    checks++; if (drop_pulse !== 1'b1 || drop_reason !== 3'd4) begin errors++; $display("FAIL tha_drop got %0b/%0d want 1/4", drop_pulse, drop_reason); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL tha_valid got %0b want 0", m_valid); end
    data_in = 8'($urandom);
    @(negedge aclk);
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL tha_pulse_width got %0b want 0", drop_pulse); end
    checks++; if (cnt_drop !== CNT_W'(exp_drop)) begin errors++; $display("FAIL tha_cnt_drop got %0d want %0d", cnt_drop, exp_drop); end
    finish_pkt(0);
  endtask

  task automatic test_hdr_trunc();
    drop_log.delete();
    build(16'd1, 48'h00AABBCCDDEE, 32'h0A0A0202, 48'h0, local_ip[31:0]);
    pkt[2] = 8'h86; pkt[3] = 8'hDD;
    send_bytes(28, 1'b0);
    @(negedge aclk);
    exp_drop++;
    checks++; if (drop_pulse !== 1'b1 || drop_reason !== 3'd1) begin errors++; $display("FAIL hdr_drop got %0b/%0d want 1/1", drop_pulse, drop_reason); end
    finish_pkt(3);
    checks++; if (drop_log.size() != 1) begin errors++; $display("FAIL hdr_single_report got %0d want 1", drop_log.size()); end
    drop_log.delete();
    build(16'd1, 48'h00AABBCCDDEE, 32'h0A0A0202, 48'h0, local_ip[31:0]);
    send_bytes(12, 1'b0);
    @(negedge aclk);
    data_valid = 1'b0; eth = 1'b0;
    @(negedge aclk);
    exp_drop++;
    checks++; if (drop_pulse !== 1'b1 || drop_reason !== 3'd5) begin errors++; $display("FAIL trunc_drop got %0b/%0d want 1/5", drop_pulse, drop_reason); end
    repeat (2) @(negedge aclk);
    checks++; if (cnt_drop !== CNT_W'(exp_drop) || drop_log.size() != 1) begin errors++; $display("FAIL trunc_cnt got %0d/%0d want %0d/1", cnt_drop, drop_log.size(), exp_drop); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] sha_a, sha_b, sha_c;
    sha_a = 48'h0000000000A1; sha_b = 48'h0000000000B2; sha_c = 48'h0000000000C3;
    m_ready = 1'b0;
    build(16'd1, sha_a, 32'h0A0A0303, 48'h0, local_ip[31:0]);
    send_bytes(28, 1'b0);
    @(negedge aclk);
    exp_ok++;
    checks++; if (m_valid !== 1'b1 || m_sha !== sha_a) begin errors++; $display("FAIL b2b_first got %0b/%h want 1/%h", m_valid, m_sha, sha_a); end
    finish_pkt(0);
    build(16'd1, sha_b, 32'h0A0A0304, 48'h0, local_ip[31:0]);
    send_bytes(28, 1'b0);
    @(negedge aclk);
    exp_drop++;
    checks++; if (drop_pulse !== 1'b1 || drop_reason !== 3'd6) begin errors++; $display("FAIL b2b_overflow got %0b/%0d want 1/6", drop_pulse, drop_reason); end
    checks++; if (m_valid !== 1'b1 || m_sha !== sha_a) begin errors++; $display("FAIL b2b_held got %0b/%h want 1/%h", m_valid, m_sha, sha_a); end
    finish_pkt(1);
    build(16'd1, sha_c, 32'h0A0A0305, 48'h0, local_ip[63:32]);
    send_bytes(28, 1'b1);
    @(negedge aclk);
    exp_ok++;
    checks++; if (m_valid !== 1'b1 || m_sha !== sha_c || m_ip_idx !== 1'b1) begin errors++; $display("FAIL b2b_third got %0b/%h/%0d want 1/%h/1", m_valid, m_sha, m_ip_idx, sha_c); end
    checks++; if (drop_pulse !== 1'b0 || cnt_ok !== CNT_W'(exp_ok)) begin errors++; $display("FAIL b2b_third_cnt got %0b/%0d want 0/%0d", drop_pulse, cnt_ok, exp_ok); end
    data_in = 8'($urandom); eth = 1'b0;
    @(negedge aclk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_release got %0b want 0", m_valid); end
    finish_pkt(0);
  endtask

  task automatic test_grat();
    m_ready = 1'b1; ip_en = 2'b11;
    build(16'd1, 48'h001111111111, 32'h0A000005, 48'h0, 32'h0A000005);
    send_bytes(28, 1'b0);
    @(negedge aclk);
    exp_ok++;
    checks++; if (m_valid !== 1'b1 || m_grat !== 1'b1 || m_ip_idx !== 1'b0) begin errors++; $display("FAIL grat_accept got %0b/%0b/%0d want 1/1/0", m_valid, m_grat, m_ip_idx); end
    checks++; if (m_spa !== 32'h0A000005) begin errors++; $display("FAIL grat_spa got %h want 0a000005", m_spa); end
    finish_pkt(0);
    ip_en = 2'b00;
    build(16'd1, 48'h001111111111, 32'h0A000006, 48'h0, local_ip[63:32]);
    send_bytes(28, 1'b0);
    @(negedge aclk);
    exp_drop++;
    checks++; if (drop_pulse !== 1'b1 || drop_reason !== 3'd3 || m_valid !== 1'b0) begin errors++; $display("FAIL noip_drop got %0b/%0d/%0b want 1/3/0", drop_pulse, drop_reason, m_valid); end
    finish_pkt(0);
    ip_en = 2'b11;
  endtask

  task automatic test_midreset();
    m_ready = 1'b0;
    build(16'd1, 48'h002222222222, 32'h0A0A0404, 48'h0, local_ip[31:0]);
    send_bytes(28, 1'b0);
    @(negedge aclk);
    finish_pkt(0);
    drop_log.delete();
    build(16'd1, 48'h003333333333, 32'h0A0A0405, 48'h0, local_ip[31:0]);
    send_bytes(16, 1'b0);
    areset = 1'b1;
    #1;
    exp_ok = 0; exp_drop = 0;
    checks++; if ({m_valid, drop_pulse, m_sha, m_spa, m_tha, m_grat, m_oper} !== '0) begin errors++; $display("FAIL rst_outputs got valid=%0b sha=%h want 0", m_valid, m_sha); end
    checks++; if (cnt_ok !== '0 || cnt_drop !== '0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", cnt_ok, cnt_drop); end
    @(negedge aclk);
    data_valid = 1'b0; eth = 1'b0; areset = 1'b0;
    repeat (3) @(negedge aclk);
    checks++; if (drop_log.size() != 0) begin errors++; $display("FAIL rst_no_drop got %0d want 0", drop_log.size()); end
    m_ready = 1'b1;
    build(16'd1, 48'h004444444444, 32'h0A0A0406, 48'h0, local_ip[31:0]);
    send_bytes(28, 1'b0);
    @(negedge aclk);
    exp_ok++;
    checks++; if (m_valid !== 1'b1 || m_sha !== 48'h004444444444 || cnt_ok !== CNT_W'(exp_ok)) begin errors++; $display("FAIL rst_fresh got %0b/%h/%0d want 1/004444444444/%0d", m_valid, m_sha, cnt_ok, exp_ok); end
    finish_pkt(0);
  endtask

  task automatic test_random();
    int kind, n;
    logic [2:0] r;
    logic [0:0] eidx;
    logic egrat;
    logic [47:0] sha, tha;
    logic [31:0] spa, tpa;
    m_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      ip_en = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 7);
      sha = {16'($urandom), 32'($urandom)};
      spa = 32'($urandom);
      tpa = local_ip[32*$urandom_range(0, 1) +: 32];
      tha = {16'($urandom), 32'($urandom)};
      n = 28;
      case (kind)
        0: build(16'd1, sha, spa, tha, tpa);
        1: build(16'd2, sha, spa, local_mac, tpa);
        2: build(16'd2, sha, spa, tha, tpa);
        3: build(16'($urandom_range(1, 2)), sha, spa, tha, spa);
        4: begin build(16'd1, sha, spa, tha, tpa); pkt[$urandom_range(0, 5)] ^= 8'($urandom_range(1, 255)); end
        5: begin build(16'd1, sha, spa, tha, tpa); pkt[6] = 8'($urandom_range(1, 255)); end
        6: build(16'd1, sha, spa, tha, 32'($urandom));
        default: begin build(16'd1, sha, spa, tha, tpa); n = $urandom_range(8, 27); end
      endcase
      r = model(n, eidx, egrat);
      send_bytes(n, 1'b0);
      if (n < 28) begin
        @(negedge aclk);
        data_valid = 1'b0; eth = 1'b0;
      end
      @(negedge aclk);
      checks++; if (drop_pulse !== (r != 3'd0) || (r != 3'd0 && drop_reason !== r)) begin errors++; $display("FAIL rand_drop it=%0d kind=%0d got %0b/%0d want reason %0d", it, kind, drop_pulse, drop_reason, r); end
      checks++; if (m_valid !== (r == 3'd0)) begin errors++; $display("FAIL rand_valid it=%0d kind=%0d got %0b want %0b", it, kind, m_valid, (r == 3'd0)); end
      if (r == 3'd0) begin
        exp_ok++;
        checks++; if (m_sha !== {pkt[8], pkt[9], pkt[10], pkt[11], pkt[12], pkt[13]} || m_spa !== {pkt[14], pkt[15], pkt[16], pkt[17]} || m_tha !== {pkt[18], pkt[19], pkt[20], pkt[21], pkt[22], pkt[23]}) begin errors++; $display("FAIL rand_addr it=%0d got sha=%h spa=%h tha=%h", it, m_sha, m_spa, m_tha); end
        checks++; if (m_oper !== (pkt[7] == 8'h02) || m_ip_idx !== eidx || m_grat !== egrat) begin errors++; $display("FAIL rand_meta it=%0d got %0b/%0d/%0b want %0b/%0d/%0b", it, m_oper, m_ip_idx, m_grat, (pkt[7] == 8'h02), eidx, egrat); end
      end else begin
        exp_drop++;
      end
      finish_pkt((n < 28) ? 0 : $urandom_range(0, 3));
    end
    checks++; if (cnt_ok !== CNT_W'(exp_ok) || cnt_drop !== CNT_W'(exp_drop)) begin errors++; $display("FAIL rand_counters got %0d/%0d want %0d/%0d", cnt_ok, cnt_drop, exp_ok, exp_drop); end
    ip_en = 2'b11;
  endtask

  initial begin
    local_mac = 48'h02AABBCCDD01;
    local_ip  = {32'hC0A8000A, 32'hC0A80001};
    ip_en     = 2'b11;
    m_ready   = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    test_reset();
    test_request();
    test_tha_miss();
    test_hdr_trunc();
    test_back_to_back();
    test_grat();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
